spi_master_par: RTL

- Parallel-mode SPI master that drives one shared sclk/mosi pair, a dedicated active-low chip select per slave, and a dedicated miso input per slave.
- Executes an echo transaction against the selected slave: 8 bits out on mosi (LSB first), then 8 bits back on miso (LSB first).
- Slave timing it must satisfy: the slave samples mosi on sclk falling edges 1–8 and drives miso on falling edges 9–16.
- Sits between the system-side command logic and the slave bank.

---
 rtl/spi_master_par.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_par.sv
// spi_master_par: SPI master with shared sclk/mosi, one cs_n and one miso per slave.
// Sends one byte LSB first, then reads one byte back LSB first.
// Optional feature macro: SPI_ECHO_CHECK_EN (flags a mismatch between sent and received byte).
module spi_master_par #(
   parameter int CLK_DIV    = 2,
   parameter int NUM_SLAVES = 2,
   parameter int SEL_W      = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic [7:0]            tx_data,
   output logic                  sclk,
   output logic [NUM_SLAVES-1:0] cs_n,
   output logic                  mosi,
   input  logic [NUM_SLAVES-1:0] miso,
   output logic [7:0]            rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  echo_err
);

   localparam int              HC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CS_OFF, FINISH} state_t;

   state_t                  state_q, state_d;
   logic [HC_W-1:0]         hc_q, hc_d;
   logic [5:0]              ec_q, ec_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [7:0]              tx_q, tx_d;
   logic [7:0]              rx_shift_q, rx_shift_d;
   logic [7:0]              rx_data_q, rx_data_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [NUM_SLAVES-1:0]   cs_n_q, cs_n_d;
   logic [NUM_SLAVES-1:0]   cs_sel_n;
   logic                    miso_sel;
   logic                    tick;
   logic                    sel_ok;
   logic [5:0]              k;
   logic [2:0]              tx_bit;
   logic [2:0]              rx_bit;

   // Decode the latched slave index into a cs mask and pick that slave's miso line
   always_comb begin
      cs_sel_n = '1;
      miso_sel = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SEL_W'(i)) begin
            cs_sel_n[i] = 1'b0;
            miso_sel    = miso[i];
         end
      end
   end

   // Next-state and output logic; every action happens on a half-period boundary (tick)
   always_comb begin
      state_d    = state_q;
      ec_d       = ec_q;
      sel_d      = sel_q;
      tx_d       = tx_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      cs_n_d     = cs_n_q;
      tick       = (hc_q == '0);
      sel_ok     = (32'(slave_sel) < NUM_SLAVES);
      // k is the rising-edge number when ec_q is odd
      k          = (ec_q + 6'd1) >> 1;
      tx_bit     = 3'(k - 6'd1);
      rx_bit     = 3'(k - 6'd10);

      if (state_q == IDLE)        hc_d = '0;
      else if (hc_q == HC_MAX)    hc_d = '0;
      else                        hc_d = hc_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (start && sel_ok) begin
               sel_d   = slave_sel;
               tx_d    = tx_data;
               busy_d  = 1'b1;
               ec_d    = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               if (ec_q == 6'd0) begin
                  // H0: select the slave with bit 0 already on mosi
                  sclk_d = 1'b0;
                  cs_n_d = cs_sel_n;
                  mosi_d = tx_q[0];
                  ec_d   = 6'd1;
               end else begin
                  // H1: first rising edge, mosi keeps bit 0
                  sclk_d  = 1'b1;
                  ec_d    = 6'd2;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (tick) begin
               ec_d = ec_q + 6'd1;
               if (ec_q[0]) begin
                  sclk_d = 1'b1;
                  if (k <= 6'd8) mosi_d = tx_q[tx_bit];
                  else           mosi_d = 1'b0;
                  // miso bit was driven on the previous falling edge
                  if (k >= 6'd10) rx_shift_d[rx_bit] = miso_sel;
                  if (ec_q == 6'd33) state_d = CS_OFF;
               end else begin
                  sclk_d = 1'b0;
               end
            end
         end
         CS_OFF: begin
            if (tick) begin
               // release cs while sclk is high so the last falling edge is seen deselected
               cs_n_d  = '1;
               ec_d    = ec_q + 6'd1;
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (tick) begin
               sclk_d    = 1'b0;
               rx_data_d = rx_shift_q;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               ec_d      = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hc_q      <= '0;
         ec_q      <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= '1;
         mosi_q    <= 1'b0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         ec_q      <= ec_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Datapath registers need no reset: they are always loaded before use
   always_ff @(posedge clk) begin
      sel_q      <= sel_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
   end

`ifdef SPI_ECHO_CHECK_EN
   logic echo_err_q, echo_err_d;

   // Compare the returned byte against the sent byte at transaction end
   always_comb begin
      echo_err_d = echo_err_q;
      if (state_q == FINISH && tick) echo_err_d = (rx_shift_q != tx_q);
   end

   // Echo flag register, held until the next done or reset
   always_ff @(posedge clk) begin
      if (!rst_n) echo_err_q <= 1'b0;
      else        echo_err_q <= echo_err_d;
   end

   assign echo_err = echo_err_q;
`else
   assign echo_err = 1'b0;
`endif

   assign sclk    = sclk_q;
   assign cs_n    = cs_n_q;
   assign mosi    = mosi_q;
   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
